// File: rtl/life_pkg.sv
// Shared constants and FSM encoding for the Game-of-Life pattern store path.
package life_pkg;

  localparam int BOARD_ROWS = 128;
  localparam int ROW_W      = 128;
  localparam int SLOT_W     = 3;
  localparam int ROW_AW     = 7;
  localparam int PAT_AW     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } ps_state_e;

endpackage

// File: rtl/tag_delay.sv
// Fixed-depth shift register that carries a {valid, row} tag alongside a board read.
module tag_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_tag,
  output logic [W-1:0] o_tag
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/pattern_store.sv
// Writes one 128-row slot of the patterns BRAM, either as a copy of the live
// board or as all zeros.
//
// state | meaning
// IDLE  | waiting for start; row 0 is issued on the accepting edge
// ISSUE | issuing board reads for rows 1..ROWS-1
// DRAIN | reads done, waiting for the last row write to leave the pipeline
// FIN   | one-cycle done pulse, start ignored
module pattern_store
  import life_pkg::*;
#(
  parameter int ROWS      = BOARD_ROWS,
  parameter int WIDTH     = ROW_W,
  parameter int SLOT_BITS = SLOT_W,
  parameter int RD_LAT    = 1
) (
  input  logic                               clka,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               clear,
  input  logic [SLOT_BITS-1:0]               slot,
  output logic                               board_re,
  output logic [$clog2(ROWS)-1:0]            board_addr,
  input  logic [WIDTH-1:0]                   board_row,
  output logic                               wea,
  output logic [SLOT_BITS+$clog2(ROWS)-1:0]  addra,
  output logic [WIDTH-1:0]                   dina,
  output logic                               busy,
  output logic                               done
);

  localparam int RAW = $clog2(ROWS);
  localparam int CW  = RAW + 1;

  ps_state_e            r_state;
  logic [SLOT_BITS-1:0] r_slot;
  logic                 r_clr;
  logic [CW-1:0]        r_rc;
  logic                 r_iss_vld;

  logic [RAW:0]         w_tag_in;
  logic [RAW:0]         w_tag_out;
  logic                 w_tag_vld;
  logic [RAW-1:0]       w_tag_row;
  logic                 w_last_wr;

  // rc holds the next row to issue; row 0 goes out on the accepting edge
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_clr      <= 1'b0;
      r_rc       <= '0;
      r_iss_vld  <= 1'b0;
      board_re   <= 1'b0;
      board_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_slot     <= slot;
            r_clr      <= clear;
            r_rc       <= CW'(1);
            r_iss_vld  <= 1'b1;
            board_addr <= '0;
            board_re   <= ~clear;
            busy       <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          board_addr <= r_rc[RAW-1:0];
          r_rc       <= r_rc + CW'(1);
          if (r_rc == CW'(ROWS - 1)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          r_iss_vld <= 1'b0;
          board_re  <= 1'b0;
          if (w_last_wr) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_tag_in  = {r_iss_vld, board_addr};
  assign w_tag_vld = w_tag_out[RAW];
  assign w_tag_row = w_tag_out[RAW-1:0];
  assign w_last_wr = wea && (addra[RAW-1:0] == RAW'(ROWS - 1));

  tag_delay #(
    .DEPTH (RD_LAT),
    .W     (RAW + 1)
  ) u_tag_delay (
    .i_clk   (clka),
    .i_rst_n (rst_n),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      wea <= w_tag_vld;
      if (w_tag_vld) begin
        addra <= {r_slot, w_tag_row};
        dina  <= r_clr ? '0 : board_row;
      end
    end
  end

endmodule

// File: tb/tb_pattern_store.sv
// Self-checking bench for pattern_store: RD_LAT=1 and RD_LAT=3 instances side by side.
module tb_pattern_store;
  import life_pkg::*;

  localparam int ROWS = BOARD_ROWS;
  localparam int NONE = 32'h3fff_ffff;

  typedef struct packed {
    int         cyc;
    int         addr;
    logic [127:0] data;
  } wr_t;

  typedef struct {
    int slot;
    int clr;
    int lo;
    int hi;
  } vec_t;

  typedef struct {
    int lat;
    int slot;
    int clr;
    int t0;
    int trst;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start1, start3, clear;
  logic [2:0]   slot;
  logic         re1, re3, wea1, wea3, busy1, busy3, done1, done3;
  logic [6:0]   ba1, ba3;
  logic [127:0] br1, br3, dina1, dina3;
  logic [9:0]   addra1, addra3;

  pattern_store #(.RD_LAT(1)) dut1 (
    .clka(clk), .rst_n(rst_n), .start(start1), .clear(clear), .slot(slot),
    .board_re(re1), .board_addr(ba1), .board_row(br1),
    .wea(wea1), .addra(addra1), .dina(dina1), .busy(busy1), .done(done1)
  );

  pattern_store #(.RD_LAT(3)) dut3 (
    .clka(clk), .rst_n(rst_n), .start(start3), .clear(clear), .slot(slot),
    .board_re(re3), .board_addr(ba3), .board_row(br3),
    .wea(wea3), .addra(addra3), .dina(dina3), .busy(busy3), .done(done3)
  );

  // board memory model; unread cycles return junk so clear mode must ignore it
  logic [127:0] mem [ROWS];
  logic [127:0] p3a, p3b;

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    br1 <= re1 ? mem[ba1] : junk();
    p3a <= re3 ? mem[ba3] : junk();
    p3b <= p3a;
    br3 <= p3b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t act1[$], act3[$], exp_w[$];
  int  dn1[$], dn3[$], exp_d[$];
  int  rec1 = 0, rec3 = 0, viol1 = 0, viol3 = 0, exp_re = 0;
  op_t ops[$];
  int  checks = 0, errors = 0;

  always @(negedge clk) begin : mon
    wr_t w;
    if (wea1) begin
      w.cyc = cyc; w.addr = int'(addra1); w.data = dina1;
      act1.push_back(w);
      if (!busy1) viol1++;
    end
    if (wea3) begin
      w.cyc = cyc; w.addr = int'(addra3); w.data = dina3;
      act3.push_back(w);
      if (!busy3) viol3++;
    end
    if (done1) dn1.push_back(cyc);
    if (done3) dn3.push_back(cyc);
    if (re1) rec1++;
    if (re3) rec3++;
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic start_both(input int s, input int c, output int t0);
    slot   = 3'(s);
    clear  = (c != 0);
    start1 = 1'b1;
    start3 = 1'b1;
    t0     = cyc;
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic add_op(input int lat, input int s, input int c, input int t0, input int trst);
    op_t o;
    o.lat = lat; o.slot = s; o.clr = c; o.t0 = t0; o.trst = trst;
    ops.push_back(o);
  endtask

  // Reference: every row r of an operation started in cycle t0 is read in
  // t0+1+r and written in t0+lat+2+r at slot*ROWS+r; done follows the last write.
  task automatic expect_op(input int lat, input op_t o);
    wr_t w;
    for (int r = 0; r < ROWS; r++) begin
      w.cyc  = o.t0 + lat + 2 + r;
      w.addr = o.slot * ROWS + r;
      w.data = (o.clr != 0) ? 128'd0 : mem[r];
      if (w.cyc < o.trst) exp_w.push_back(w);
      if (o.clr == 0 && o.t0 + 1 + r < o.trst) exp_re++;
    end
    if (o.t0 + ROWS + lat + 2 < o.trst) exp_d.push_back(o.t0 + ROWS + lat + 2);
  endtask

  task automatic compare(input int lat, input string nm);
    wr_t a[$];
    int  d[$];
    int  rc, v;
    if (lat == 1) begin a = act1; d = dn1; rc = rec1; v = viol1; end
    else          begin a = act3; d = dn3; rc = rec3; v = viol3; end
    chk($sformatf("%s L%0d write count", nm, lat), a.size(), exp_w.size());
    for (int i = 0; i < a.size() && i < exp_w.size(); i++) begin
      checks++;
      if (a[i] != exp_w[i]) begin
        errors++;
        $display("FAIL %s L%0d write %0d: got cyc=%0d addr=%0d data=%h, expected cyc=%0d addr=%0d data=%h",
                 nm, lat, i, a[i].cyc, a[i].addr, a[i].data, exp_w[i].cyc, exp_w[i].addr, exp_w[i].data);
      end
    end
    chk($sformatf("%s L%0d done count", nm, lat), d.size(), exp_d.size());
    for (int i = 0; i < d.size() && i < exp_d.size(); i++)
      chk($sformatf("%s L%0d done cycle %0d", nm, lat, i), d[i], exp_d[i]);
    chk($sformatf("%s L%0d board_re cycles", nm, lat), rc, exp_re);
    chk($sformatf("%s L%0d wea outside busy", nm, lat), v, 0);
  endtask

  task automatic finish_scn(input string nm);
    for (int k = 0; k < 2; k++) begin
      int lat;
      lat = (k == 0) ? 1 : 3;
      exp_w.delete(); exp_d.delete(); exp_re = 0;
      foreach (ops[j]) if (ops[j].lat == 0 || ops[j].lat == lat) expect_op(lat, ops[j]);
      compare(lat, nm);
    end
    ops.delete(); exp_w.delete(); exp_d.delete();
    act1.delete(); act3.delete(); dn1.delete(); dn3.delete();
    rec1 = 0; rec3 = 0; viol1 = 0; viol3 = 0;
  endtask

  task automatic tbl_chk(input int lat, input int t0, input vec_t tv, input string nm);
    wr_t a[$];
    int  d[$];
    int  fa, la, fc, lc, dc;
    if (lat == 1) begin a = act1; d = dn1; end
    else          begin a = act3; d = dn3; end
    fa = -1; la = -1; fc = -1; lc = -1; dc = -1;
    if (a.size() > 0) begin
      fa = a[0].addr; la = a[a.size()-1].addr;
      fc = a[0].cyc - t0; lc = a[a.size()-1].cyc - t0;
    end
    if (d.size() > 0) dc = d[0] - t0;
    chk($sformatf("%s L%0d first addra", nm, lat), fa, tv.lo);
    chk($sformatf("%s L%0d last addra", nm, lat), la, tv.hi);
    chk($sformatf("%s L%0d first write offset", nm, lat), fc, lat + 2);
    chk($sformatf("%s L%0d last write offset", nm, lat), lc, ROWS + lat + 1);
    chk($sformatf("%s L%0d done offset", nm, lat), dc, ROWS + lat + 2);
  endtask

  task automatic rand_mem();
    for (int r = 0; r < ROWS; r++) mem[r] = junk();
  endtask

  initial begin
    vec_t tbl[4];
    int   t0, t0b;
    vec_t tv;

    tbl[0].slot = 2; tbl[0].clr = 0; tbl[0].lo = 256; tbl[0].hi = 383;
    tbl[1].slot = 7; tbl[1].clr = 1; tbl[1].lo = 896; tbl[1].hi = 1023;
    tbl[2].slot = 0; tbl[2].clr = 0; tbl[2].lo = 0;   tbl[2].hi = 127;
    tbl[3].slot = 5; tbl[3].clr = 1; tbl[3].lo = 640; tbl[3].hi = 767;

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; clear = 1'b0; slot = '0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    repeat (3) @(negedge clk);
    chk("reset board_re", {re1, re3}, 0);
    chk("reset board_addr", {ba1, ba3}, 0);
    chk("reset wea", {wea1, wea3}, 0);
    chk("reset addra", {addra1, addra3}, 0);
    chk("reset dina", (dina1 | dina3) != 0, 0);
    chk("reset busy", {busy1, busy3}, 0);
    chk("reset done", {done1, done3}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    finish_scn("reset");

    for (int i = 0; i < 4; i++) begin
      if (i == 0) for (int r = 0; r < ROWS; r++) mem[r] = {16{8'(r)}};
      else rand_mem();
      tv = tbl[i];
      start_both(tv.slot, tv.clr, t0);
      wait_until(t0 + 140);
      tbl_chk(1, t0, tv, $sformatf("vec%0d", i));
      tbl_chk(3, t0, tv, $sformatf("vec%0d", i));
      add_op(0, tv.slot, tv.clr, t0, NONE);
      finish_scn($sformatf("vec%0d", i));
    end

    // start while busy must not disturb the latched slot/clear
    rand_mem();
    start_both(5, 0, t0);
    wait_until(t0 + 20);
    slot = 3'd0; clear = 1'b1; start1 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    wait_until(t0 + 140);
    add_op(0, 5, 0, t0, NONE);
    finish_scn("busy_start");

    // reset mid-operation: reset outputs visible in cycle t0+50
    rand_mem();
    start_both(1, 0, t0);
    wait_until(t0 + 49);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst wea L1", wea1, 0);
    chk("midrst busy L1", busy1, 0);
    chk("midrst wea L3", wea3, 0);
    chk("midrst busy L3", busy3, 0);
    rst_n = 1'b1;
    wait_until(t0 + 200);
    if (act1.size() > 0) chk("midrst last addra L1", act1[act1.size()-1].addr, 174);
    else chk("midrst L1 writes present", 0, 1);
    add_op(0, 1, 0, t0, t0 + 50);
    finish_scn("midrst");

    // randomized operations
    for (int i = 0; i < 4; i++) begin
      int s, c;
      rand_mem();
      s = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 1));
      start_both(s, c, t0);
      wait_until(t0 + 140);
      add_op(0, s, c, t0, NONE);
      finish_scn($sformatf("rand%0d", i));
    end

    // back-to-back: second start lands the cycle after each instance's done
    rand_mem();
    start_both(4, 0, t0);
    wait_until(t0 + ROWS + 1 + 3);
    t0b = cyc;
    slot = 3'd3; clear = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    add_op(1, 4, 0, t0, NONE);
    add_op(1, 3, 0, t0b, NONE);
    wait_until(t0 + ROWS + 3 + 3);
    t0b = cyc;
    slot = 3'd3; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    add_op(3, 4, 0, t0, NONE);
    add_op(3, 3, 0, t0b, NONE);
    wait_until(t0b + 140);
    finish_scn("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
